// File: rtl/input_router_xy.sv
// XY input router: one-hot port request for head flits, per-ID table so body/tail follow the head.
// Latency: 1 cycle, registered flit/port/valid. Optional orphan drop + error count under `ROUTE_ERR_EN.
// Backpressure: flit_ready_o = !flit_valid_o || flit_ready_i; outputs hold stable while stalled.
module input_router_xy #(
    parameter int FLIT_WIDTH = 40,
    parameter int NOC_X      = 4,
    parameter int NOC_Y      = 4,
    parameter int ROUTER_X   = 0,
    parameter int ROUTER_Y   = 0,
    parameter int NUM_IDS    = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  flit_valid_i,
    output logic                  flit_ready_o,
    input  logic [FLIT_WIDTH-1:0] flit_i,
    output logic                  flit_valid_o,
    input  logic                  flit_ready_i,
    output logic [FLIT_WIDTH-1:0] flit_o,
    output logic [4:0]            router_port_o,
    output logic                  err_o,
    output logic [7:0]            err_cnt_o
);
    localparam int X_W   = $clog2(NOC_X);
    localparam int Y_W   = $clog2(NOC_Y);
    localparam int ID_W  = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;
    localparam int TBL_N = 1 << ID_W;
    localparam logic [X_W-1:0] RX = X_W'(ROUTER_X);
    localparam logic [Y_W-1:0] RY = Y_W'(ROUTER_Y);

    localparam logic [4:0] P_LOCAL = 5'b00001;
    localparam logic [4:0] P_NORTH = 5'b00010;
    localparam logic [4:0] P_SOUTH = 5'b00100;
    localparam logic [4:0] P_WEST  = 5'b01000;
    localparam logic [4:0] P_EAST  = 5'b10000;

    typedef enum logic [1:0] {
        FT_SINGLE = 2'b00,
        FT_HEAD   = 2'b01,
        FT_BODY   = 2'b10,
        FT_TAIL   = 2'b11
    } flit_type_e;

    typedef struct packed {
        logic       vld;
        logic [4:0] port;
    } rt_entry_t;

    flit_type_e      ftype;
    logic [ID_W-1:0] fid;
    logic [X_W-1:0]  dest_x;
    logic [Y_W-1:0]  dest_y;
    logic [4:0]      xy_port;
    logic [4:0]      next_port;
    logic            head_like;
    logic            orphan;
    logic            acc_vld;
    logic            drop;
    rt_entry_t       ent;
    rt_entry_t       tbl [TBL_N];

    assign ftype  = flit_type_e'(flit_i[1:0]);
    assign fid    = flit_i[2 +: ID_W];
    assign dest_x = flit_i[FLIT_WIDTH-1 -: X_W];
    assign dest_y = flit_i[FLIT_WIDTH-1-X_W -: Y_W];

    // X is resolved first; Y only once the column matches.
    always_comb begin
        xy_port = P_LOCAL;
        if (dest_x > RX)      xy_port = P_EAST;
        else if (dest_x < RX) xy_port = P_WEST;
        else if (dest_y < RY) xy_port = P_NORTH;
        else if (dest_y > RY) xy_port = P_SOUTH;
    end

    assign ent       = tbl[fid];
    assign head_like = (ftype == FT_SINGLE) || (ftype == FT_HEAD);
    assign orphan    = !head_like && !ent.vld;
    assign next_port = head_like ? xy_port : (orphan ? P_LOCAL : ent.port);

    assign flit_ready_o = !flit_valid_o || flit_ready_i;
    assign acc_vld      = flit_valid_i && flit_ready_o;

`ifdef ROUTE_ERR_EN
    assign drop = orphan;
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int i = 0; i < TBL_N; i++) tbl[i] <= '0;
        end else if (acc_vld) begin
            if (ftype == FT_HEAD)      tbl[fid] <= '{vld: 1'b1, port: xy_port};
            else if (ftype == FT_TAIL) tbl[fid].vld <= 1'b0;
        end
    end

    // Everything is gated by flit_ready_o, which is exactly the "not stalled" condition.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            flit_valid_o  <= 1'b0;
            flit_o        <= '0;
            router_port_o <= '0;
        end else if (flit_ready_o) begin
            flit_valid_o <= acc_vld && !drop;
            if (acc_vld && !drop) begin
                flit_o        <= flit_i;
                router_port_o <= next_port;
            end
        end
    end

`ifdef ROUTE_ERR_EN
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            err_o <= acc_vld && orphan;
            if (acc_vld && orphan && (err_cnt_o != 8'hFF))
                err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`else
    assign err_o     = 1'b0;
    assign err_cnt_o = 8'd0;
`endif
endmodule
